// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage pipeline register: 2-entry skid buffer with valid/ready and sync flush.
// Optional perf counters (stall_cycles, bubble_cycles) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W     = 128,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_cycles,
`endif
    output logic [1:0]        occupancy
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("DATA_W must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;
    logic [1:0]        occ_q, occ_d;
    logic              acc, pop;

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign occupancy = occ_q;

    assign acc = in_valid & in_ready;
    assign pop = main_v_q & out_ready;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            // Payloads stay put so out_data keeps its last value; only the valids drop.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            unique case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (acc) begin
                        main_d_d = in_data;
                        main_v_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (pop && acc) begin
                        main_d_d = in_data;
                    end else if (pop) begin
                        main_v_d = 1'b0;
                    end else if (acc) begin
                        skid_d_d = in_data;
                        skid_v_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (pop) begin
                        main_d_d = skid_d_q;
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                    // Unreachable; recover to empty rather than hold a skid with no main.
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
        occ_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_d_q <= RESET_DATA;
            skid_d_q <= '0;
            occ_q    <= 2'd0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
            occ_q    <= occ_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q;

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;

    // Saturating counters sampled from pre-edge state; flush does not clear them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_v_q && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (!main_v_q && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: queue-based reference model, negedge monitor.
// Checks perf counters too when built with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_buf;

    localparam int unsigned       DW    = 32;
    localparam int unsigned       CW    = 4;
    localparam logic [DW-1:0]     RDATA = 32'hDEAD_BEEF;
    localparam int                CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] bubble_cycles;
`endif

    pipe_stage_buf #(
        .DATA_W    (DW),
        .RESET_DATA(RDATA),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles),
`endif
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: in-flight payloads in arrival order, capacity 2.
    logic [DW-1:0] sb[$];
    logic [DW-1:0] shown_m;
    int            stall_m, bubble_m, sz_m;
    bit            acc_m, pop_m, last_acc;

    always @(posedge clk) begin
        sz_m  = sb.size();
        acc_m = in_valid && (sz_m < 2);
        pop_m = (sz_m > 0) && out_ready;
        if (!rst_n) begin
            sb.delete();
            shown_m  = RDATA;
            stall_m  = 0;
            bubble_m = 0;
            last_acc = 1'b0;
        end else begin
            if (sz_m > 0 && !out_ready && stall_m < CMAX) stall_m++;
            if (sz_m == 0 && bubble_m < CMAX) bubble_m++;
            last_acc = acc_m && !flush;
            if (flush) begin
                sb.delete();
            end else begin
                if (pop_m) void'(sb.pop_front());
                if (acc_m) sb.push_back(in_data);
            end
            if (sb.size() > 0) shown_m = sb[0];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("occupancy", DW'(occupancy), DW'(sb.size()));
            check("out_valid", DW'(out_valid), DW'(sb.size() > 0));
            check("in_ready", DW'(in_ready), DW'(sb.size() < 2));
            check("out_data", out_data, shown_m);
            n_vec++;
            if (out_valid === 1'b0 && in_ready === 1'b0) begin
                n_err++;
                $display("FAIL illegal_state: got out_valid=0 in_ready=0 expected not both 0 at %0t",
                         $time);
            end
`ifdef PIPE_STAGE_PERF_EN
            check("stall_cycles", DW'(stall_cycles), DW'(stall_m));
            check("bubble_cycles", DW'(bubble_cycles), DW'(bubble_m));
`endif
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [DW-1:0] seq;
    int            pct;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        out_ready = 1'b0;
        flush     = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst_n = 1'b1;
        in_valid = 1'b0;
        cyc(2);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            in_valid  = 1'b1;
            in_data   = DW'(i);
            out_ready = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        cyc(2);

        // Backpressure fill then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        cyc();
        in_data = 32'h22;
        cyc();
        in_data = 32'h99;
        cyc(2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(3);

        // Flush wins over a same-cycle accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        cyc();
        in_data = 32'h55;
        cyc();
        flush   = 1'b1;
        in_data = 32'h33;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        cyc(2);

        // Long stall to saturate the stall counter, then flush into bubbles
        in_valid = 1'b1;
        in_data  = 32'h66;
        cyc();
        in_valid = 1'b0;
        cyc(20);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc(5);

        // Randomised pressure on an incrementing payload, with rare flushes and one reset
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        seq   = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            pct       = ((i / 1000) % 2 == 1) ? 30 : 80;
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < pct);
            flush     = ($urandom_range(0, 63) == 0);
            rst_n     = (i != 5000);
            in_data   = in_valid ? seq : $urandom;
            cyc();
            if (last_acc) seq = seq + 1;
        end
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised, elastic successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload bus between stages with a valid/ready handshake in place of a global stall wire.
- A 2-entry skid buffer keeps in_ready registered, gives full throughput, and stops ready from combining through the stages.
- Synchronous flush for exceptions, ERET and branch kill.

Parameters:
DATA_W, 128, payload width in bits; packed PC/PC4/Inst/control/fault fields, minimum 1
RESET_DATA, 0, value loaded into out_data on reset, width DATA_W
CNT_W, 32, performance counter width, used only with PIPE_STAGE_PERF_EN

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  upstream stage presents a payload
in_ready  output  1  buffer can accept; driven directly from a register
in_data  input  DATA_W  upstream payload
flush  input  1  synchronous kill of all held entries
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream stage accepts
out_data  output  DATA_W  downstream payload, registered
occupancy  output  2  entries held: 0, 1 or 2
stall_cycles  output  CNT_W  cycles with out_valid=1 and out_ready=0 (macro only)
bubble_cycles  output  CNT_W  cycles with out_valid=0 (macro only)

Behaviour:
- Storage:
  - main entry (main_v, main_d) drives out_valid and out_data.
  - skid entry (skid_v, skid_d).
- Handshake signals:
  - in_ready = !skid_v (register output, no combinational path from out_ready).
  - acc = in_valid & in_ready.
  - pop = main_v & out_ready.
- Reset (rst_n=0 at a clock edge):
  - main_v=0, skid_v=0, out_data=RESET_DATA, skid_d=0, counters=0.
  - Outputs after reset: out_valid=0, in_ready=1, occupancy=0.
  - Reset mid-transfer discards all held entries.
- Flush (flush=1, rst_n=1):
  - main_v=0 and skid_v=0 next cycle; in_data offered in the same cycle is dropped even if acc=1.
  - out_data keeps its last value.
  - Flush has priority over all handshake events.
- Normal update (flush=0), state (main_v, skid_v):
  - (0,0): acc -> main_d=in_data, main_v=1.
  - (1,0):
    - pop & acc -> main_d=in_data.
    - pop & !acc -> main_v=0.
    - !pop & acc -> skid_d=in_data, skid_v=1.
  - (1,1): in_ready=0.
    - pop -> main_d=skid_d, skid_v=0.
    - !pop -> hold.
  - (0,1): illegal; must be unreachable.
- Latency and ordering:
  - Latency in_data -> out_data is 1 cycle when empty.
  - Sustained throughput is 1 transfer per cycle with out_ready=1.
  - Strict FIFO order; no payload duplicated or lost except by flush or reset.
- Payload values:
  - out_data is stable while out_valid=1 and out_ready=0.
  - in_data is ignored when acc=0.
- occupancy = main_v + skid_v, registered.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cycles and bubble_cycles ports exist, each CNT_W wide.
  - Each increments by 1 per qualifying cycle and saturates at all-ones.
  - Cleared by reset only, not by flush.
  - Counting is sampled from pre-edge state.
- Undefined:
  - Ports and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 2 cycles with in_valid=1, in_data=0xA5 -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_DATA.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with payloads 1..8 -> out_data=1..8 on consecutive cycles starting 1 cycle after the first, occupancy=1 throughout, in_ready=1.
- Backpressure fill:
  - Stimulus: out_ready=0, send 0x11 then 0x22.
  - Response: occupancy=2, in_ready=0, out_data=0x11 held.
  - Then out_ready=1 for 2 cycles -> out_data 0x11 then 0x22, in_ready back to 1 after the first pop.
- Flush priority: occupancy=2 with flush=1, in_valid=1, in_data=0x33 in the same cycle -> next cycle out_valid=0, occupancy=0; 0x33 never appears on out_data.
- Randomised pressure: random in_valid/out_ready for 10k cycles with scoreboard on an incrementing payload -> output sequence strictly increasing with no gaps, and (main_v, skid_v)=(0,1) never observed.
- PIPE_STAGE_PERF_EN, CNT_W=4:
  - Hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles saturates at 15.
  - Flush -> stall_cycles stays 15, bubble_cycles increments from the next cycle.
